dmi_req_arbiter: RTL and testbench

//  Round-robin arbiter sharing one DMI request/response channel (41b req, 34b resp) between NumReq masters,
//  e.g. the JTAG DTM and an on-chip debug/provisioning agent. One transaction is outstanding at a time.

---
 rtl/dmi_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/dmi_req_arbiter.sv | 131 +++++++++++++
 tb/tb_dmi_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// Shared DMI request/response types, op/resp codes and the arbiter state encoding.
package dmi_pkg;

  localparam logic [1:0] DTM_NOP = 2'h0;
  localparam logic [1:0] DTM_RD  = 2'h1;
  localparam logic [1:0] DTM_WR  = 2'h2;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, LOCAL} arb_state_e;

  function automatic dmi_resp_t local_resp(input logic [1:0] code);
    dmi_resp_t r;
    r.data = '0;
    r.resp = code;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping to index 0.
module rr_arbiter #(
  parameter  int NumReq = 2,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx
);

  logic [NumReq-1:0] upper_mask;
  logic [NumReq-1:0] upper_req;
  logic [NumReq-1:0] pick_from;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_mask
    assign upper_mask[gi] = (IdxW'(gi) >= rr_ptr);
  end

  assign upper_req = req & upper_mask;
  // Requests at/above the pointer take priority; otherwise wrap to the lowest index.
  assign pick_from = (|upper_req) ? upper_req : req;
  assign gnt       = pick_from & (~pick_from + NumReq'(1));

  for (genvar gb = 0; gb < IdxW; gb++) begin : g_enc
    logic [NumReq-1:0] sel;
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_sel
      assign sel[gi] = gnt[gi] & (((gi >> gb) % 2) == 1);
    end
    assign gnt_idx[gb] = |sel;
  end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI channel between NumReq masters, one transaction at a time, with
// per-requester write locking and a response watchdog.
module dmi_req_arbiter
  import dmi_pkg::*;
#(
  parameter  int NumReq     = 2,
  parameter  int TimeoutCyc = 1023,
  localparam int IdxW       = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  input  logic [NumReq*41-1:0] req_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  logic [NumReq-1:0]    unlock_i,
  output logic [NumReq-1:0]    resp_valid_o,
  output logic [33:0]          resp_o,
  input  logic [NumReq-1:0]    resp_ready_i,
  output logic [40:0]          dmi_req_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  input  logic [33:0]          dmi_resp_i,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  output logic [IdxW-1:0]      grant_idx_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int ReqW = 41;
  localparam int CntW = $clog2(TimeoutCyc + 1);

  arb_state_e      state_reg;
  logic [IdxW-1:0] rr_ptr_reg;
  logic [IdxW-1:0] grant_idx_reg;
  dmi_req_t        req_reg;
  dmi_resp_t       resp_reg;
  logic [CntW-1:0] cnt_reg;
  logic            timeout_reg;

  dmi_req_t          req_arr [NumReq];
  dmi_req_t          sel_req;
  logic [NumReq-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              wr_unlocked;
  logic              resp_phase;
  logic              resp_ack;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign req_arr[gi]      = req_i[gi*ReqW +: ReqW];
    assign resp_valid_o[gi] = resp_phase && (grant_idx_reg == IdxW'(gi));
  end

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req     (req_valid_i),
    .rr_ptr  (rr_ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_valid   = |gnt;
  assign sel_req     = req_arr[gnt_idx];
  assign wr_unlocked = |(unlock_i & gnt);
  assign resp_phase  = (state_reg == RESP) || (state_reg == LOCAL);
  assign resp_ack    = |(resp_ready_i & resp_valid_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      req_reg       <= '0;
      resp_reg      <= '0;
      cnt_reg       <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            req_reg       <= sel_req;
            grant_idx_reg <= gnt_idx;
            rr_ptr_reg    <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
            if (sel_req.op == DTM_RD || (sel_req.op == DTM_WR && wr_unlocked)) begin
              state_reg <= REQ;
            end else begin
              // Locked writes and reserved ops never reach the slave.
              state_reg <= LOCAL;
              resp_reg  <= local_resp((sel_req.op == DTM_NOP) ? DTM_SUCCESS : DTM_ERR);
            end
          end
        end
        REQ: begin
          if (dmi_req_ready_i) begin
            state_reg <= WAIT;
            cnt_reg   <= '0;
          end
        end
        WAIT: begin
          // A response arriving on the expiry cycle still wins over the watchdog.
          if (dmi_resp_valid_i) begin
            resp_reg  <= dmi_resp_i;
            state_reg <= RESP;
          end else if (cnt_reg == CntW'(TimeoutCyc - 1)) begin
            resp_reg    <= local_resp(DTM_BUSY);
            timeout_reg <= 1'b1;
            state_reg   <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CntW'(1);
          end
        end
        RESP, LOCAL: begin
          if (resp_ack) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset gating keeps the combinational handshakes quiet while rst_ni is held.
  assign req_ready_o      = (rst_ni && state_reg == IDLE) ? gnt : '0;
  assign dmi_resp_ready_o = rst_ni && (state_reg == IDLE || state_reg == WAIT);
  assign dmi_req_valid_o  = (state_reg == REQ);
  assign dmi_req_o        = req_reg;
  assign resp_o           = resp_reg;
  assign grant_idx_o      = grant_idx_reg;
  assign busy_o           = (state_reg != IDLE);
  assign timeout_o        = timeout_reg;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed bench for dmi_req_arbiter: cycle table plus hand sequences for fairness,
// watchdog, backpressure and mid-transaction reset.
module tb_dmi_req_arbiter;

  localparam logic [1:0] RD = 2'h1;
  localparam logic [1:0] WR = 2'h2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid_i = '0;
  logic [81:0] req_i = '0;
  logic [1:0]  req_ready_o;
  logic [1:0]  unlock_i = '0;
  logic [1:0]  resp_valid_o;
  logic [33:0] resp_o;
  logic [1:0]  resp_ready_i = '0;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  logic [33:0] dmi_resp_i = '0;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  logic [0:0]  grant_idx_o;
  logic        busy_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  dmi_req_arbiter #(.NumReq(2), .TimeoutCyc(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_i(req_i),
    .req_ready_o(req_ready_o), .unlock_i(unlock_i), .resp_valid_o(resp_valid_o),
    .resp_o(resp_o), .resp_ready_i(resp_ready_i), .dmi_req_o(dmi_req_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .grant_idx_o(grant_idx_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "bench hung");
  end

  typedef struct {
    logic [1:0]  rv, op0, op1, unl, rrdy;
    logic        dqr, drv;
    logic [33:0] drsp;
    logic [1:0]  e_rr, e_rv;
    logic        e_dv, e_busy;
    logic [40:0] e_dreq;
    logic [33:0] e_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [40:0] mk_req(input int r, input logic [1:0] op);
    logic [6:0]  a;
    logic [31:0] d;
    a = (r == 1) ? 7'h21 : 7'h10;
    d = (r == 1) ? 32'h1234_5678 : 32'h0;
    return {a, d, op};
  endfunction

  task automatic add(input logic [1:0] rv, op0, op1, unl, rrdy, input logic dqr, drv,
                     input logic [33:0] drsp, input logic [1:0] e_rr, input logic e_dv,
                     input logic [1:0] e_rv, input logic e_busy, input logic [40:0] e_dreq,
                     input logic [33:0] e_resp);
    vec_t v;
    v.rv = rv; v.op0 = op0; v.op1 = op1; v.unl = unl; v.rrdy = rrdy;
    v.dqr = dqr; v.drv = drv; v.drsp = drsp;
    v.e_rr = e_rr; v.e_dv = e_dv; v.e_rv = e_rv; v.e_busy = e_busy;
    v.e_dreq = e_dreq; v.e_resp = e_resp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic set_reqs(input logic [1:0] op0, input logic [1:0] op1);
    req_i = {mk_req(1, op1), mk_req(0, op0)};
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req_ready"}, req_ready_o, 0);
    chk({nm, "_resp_valid"}, resp_valid_o, 0);
    chk({nm, "_resp"}, resp_o, 0);
    chk({nm, "_dmi_req"}, dmi_req_o, 0);
    chk({nm, "_dmi_req_valid"}, dmi_req_valid_o, 0);
    chk({nm, "_dmi_resp_ready"}, dmi_resp_ready_o, 0);
    chk({nm, "_grant_idx"}, grant_idx_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_timeout"}, timeout_o, 0);
  endtask

  // Full read from requester r with an immediately ready slave.
  task automatic run_read(input int r, input logic [31:0] data, input string nm);
    int n;
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    @(negedge clk_i);
    set_reqs(RD, RD); req_valid_i = oh; dmi_req_ready_i = 1'b1;
    dmi_resp_valid_i = 1'b0; resp_ready_i = '0;
    #1;
    n = 0;
    while (req_ready_o != oh && n < 10) begin
      @(negedge clk_i); #1; n++;
    end
    chk({nm, "_accept"}, req_ready_o, oh);
    @(negedge clk_i); req_valid_i = '0; #1;
    chk({nm, "_dmi_valid"}, dmi_req_valid_o, 1);
    chk({nm, "_dmi_req"}, dmi_req_o, mk_req(r, RD));
    chk({nm, "_grant_idx"}, grant_idx_o, r);
    @(negedge clk_i); dmi_resp_valid_i = 1'b1; dmi_resp_i = {data, 2'h0}; #1;
    chk({nm, "_wait_busy"}, busy_o, 1);
    @(negedge clk_i); dmi_resp_valid_i = 1'b0; resp_ready_i = oh; #1;
    chk({nm, "_resp_valid"}, resp_valid_o, oh);
    chk({nm, "_resp"}, resp_o, {data, 2'h0});
    @(negedge clk_i); resp_ready_i = '0; dmi_req_ready_i = 1'b0; #1;
    chk({nm, "_idle"}, busy_o, 0);
  endtask

  initial begin
    logic [40:0] r0rd, r1wr, r1rd;
    int got, n;
    r0rd = mk_req(0, RD); r1wr = mk_req(1, WR); r1rd = mk_req(1, RD);

    //   rv    op0   op1   unl    rrdy  dqr drv drsp                  e_rr e_dv e_rv e_busy e_dreq e_resp
    add(2'b00, 2'h0, 2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b00, 0, 2'b00, 0, '0,   '0);
    add(2'b01, RD,   2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b01, 0, 2'b00, 0, '0,   '0);
    add(2'b00, RD,   2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b00, 1, 2'b00, 1, r0rd, '0);
    add(2'b00, RD,   2'h0, 2'b00, 2'b00, 1, 0, 34'h0,                 2'b00, 1, 2'b00, 1, r0rd, '0);
    add(2'b00, RD,   2'h0, 2'b00, 2'b00, 0, 1, {32'hCAFE0001, 2'h0},  2'b00, 0, 2'b00, 1, '0,   '0);
    add(2'b00, RD,   2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b00, 0, 2'b01, 1, '0,   {32'hCAFE0001, 2'h0});
    add(2'b00, RD,   2'h0, 2'b00, 2'b01, 0, 0, 34'h0,                 2'b00, 0, 2'b01, 1, '0,   {32'hCAFE0001, 2'h0});
    add(2'b00, 2'h0, 2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b00, 0, 2'b00, 0, '0,   '0);
    add(2'b10, 2'h0, WR,   2'b01, 2'b00, 0, 0, 34'h0,                 2'b10, 0, 2'b00, 0, '0,   '0);
    add(2'b00, 2'h0, WR,   2'b00, 2'b10, 0, 0, 34'h0,                 2'b00, 0, 2'b10, 1, '0,   {32'h0, 2'h2});
    add(2'b10, 2'h0, WR,   2'b10, 2'b00, 0, 0, 34'h0,                 2'b10, 0, 2'b00, 0, '0,   '0);
    add(2'b00, 2'h0, WR,   2'b00, 2'b00, 1, 0, 34'h0,                 2'b00, 1, 2'b00, 1, r1wr, '0);
    add(2'b00, 2'h0, WR,   2'b00, 2'b00, 0, 1, 34'h0,                 2'b00, 0, 2'b00, 1, '0,   '0);
    add(2'b00, 2'h0, WR,   2'b00, 2'b10, 0, 0, 34'h3,                 2'b00, 0, 2'b10, 1, '0,   34'h0);
    add(2'b01, 2'h0, 2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b01, 0, 2'b00, 0, '0,   '0);
    add(2'b00, 2'h0, 2'h0, 2'b00, 2'b01, 0, 0, 34'h0,                 2'b00, 0, 2'b01, 1, '0,   34'h0);
    add(2'b10, 2'h0, 2'h3, 2'b11, 2'b00, 0, 0, 34'h0,                 2'b10, 0, 2'b00, 0, '0,   '0);
    add(2'b00, 2'h0, 2'h3, 2'b00, 2'b10, 0, 0, 34'h0,                 2'b00, 0, 2'b10, 1, '0,   {32'h0, 2'h2});
    add(2'b11, RD,   RD,   2'b00, 2'b00, 0, 0, 34'h0,                 2'b01, 0, 2'b00, 0, '0,   '0);
    add(2'b11, RD,   RD,   2'b00, 2'b00, 1, 0, 34'h0,                 2'b00, 1, 2'b00, 1, r0rd, '0);
    add(2'b11, RD,   RD,   2'b00, 2'b00, 0, 1, {32'h11111111, 2'h0},  2'b00, 0, 2'b00, 1, '0,   '0);
    add(2'b11, RD,   RD,   2'b00, 2'b01, 0, 0, 34'h0,                 2'b00, 0, 2'b01, 1, '0,   {32'h11111111, 2'h0});
    add(2'b11, RD,   RD,   2'b00, 2'b00, 0, 0, 34'h0,                 2'b10, 0, 2'b00, 0, '0,   '0);
    add(2'b00, RD,   RD,   2'b00, 2'b00, 1, 0, 34'h0,                 2'b00, 1, 2'b00, 1, r1rd, '0);
    add(2'b00, RD,   RD,   2'b00, 2'b00, 0, 1, {32'h22222222, 2'h0},  2'b00, 0, 2'b00, 1, '0,   '0);
    add(2'b00, RD,   RD,   2'b00, 2'b10, 0, 0, 34'h0,                 2'b00, 0, 2'b10, 1, '0,   {32'h22222222, 2'h0});
    add(2'b00, 2'h0, 2'h0, 2'b00, 2'b00, 0, 0, 34'h0,                 2'b00, 0, 2'b00, 0, '0,   '0);

    // Reset state, observed after a clock edge with rst_ni held low.
    @(negedge clk_i); @(negedge clk_i); #1;
    check_all_zero("reset");
    @(negedge clk_i); rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      req_valid_i = vecs[i].rv; set_reqs(vecs[i].op0, vecs[i].op1);
      unlock_i = vecs[i].unl; resp_ready_i = vecs[i].rrdy;
      dmi_req_ready_i = vecs[i].dqr; dmi_resp_valid_i = vecs[i].drv; dmi_resp_i = vecs[i].drsp;
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready_o, vecs[i].e_rr);
      chk($sformatf("v%0d_dmi_req_valid", i), dmi_req_valid_o, vecs[i].e_dv);
      chk($sformatf("v%0d_resp_valid", i), resp_valid_o, vecs[i].e_rv);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      if (vecs[i].e_dv) chk($sformatf("v%0d_dmi_req", i), dmi_req_o, vecs[i].e_dreq);
      if (vecs[i].e_rv != 0) chk($sformatf("v%0d_resp", i), resp_o, vecs[i].e_resp);
      $display("vec %0d: rv=%b rr=%b dv=%b resp_valid=%b resp=%h", i, vecs[i].rv,
               req_ready_o, dmi_req_valid_o, resp_valid_o, resp_o);
    end

    // Fairness: both requesters held valid, everything else always ready.
    @(negedge clk_i);
    set_reqs(RD, RD); unlock_i = '0; req_valid_i = 2'b11; dmi_req_ready_i = 1'b1;
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h1, 2'h0}; resp_ready_i = 2'b11;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (req_ready_o != 0) begin
        chk($sformatf("fair_grant%0d", got), req_ready_o, (got % 2 == 1) ? 2'b10 : 2'b01);
        $display("fair txn %0d: grant=%b", got, req_ready_o);
        got++;
      end
    end
    chk("fair_count", got, 4);
    @(negedge clk_i); req_valid_i = '0;
    n = 0;
    #1;
    while (busy_o && n < 10) begin @(negedge clk_i); #1; n++; end
    chk("fair_drain", busy_o, 0);
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; resp_ready_i = '0;

    // Watchdog: slave accepts the request and never answers.
    @(negedge clk_i); set_reqs(RD, RD); req_valid_i = 2'b01; dmi_req_ready_i = 1'b1; #1;
    chk("to_accept", req_ready_o, 2'b01);
    @(negedge clk_i); req_valid_i = '0; #1;
    chk("to_dmi_valid", dmi_req_valid_o, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i); #1;
      chk($sformatf("to_quiet%0d", k), timeout_o, 0);
      chk($sformatf("to_wait%0d", k), resp_valid_o, 0);
    end
    @(negedge clk_i); #1;
    chk("to_pulse", timeout_o, 1);
    chk("to_resp_valid", resp_valid_o, 2'b01);
    chk("to_resp", resp_o, {32'h0, 2'h3});
    $display("timeout txn: timeout=%b resp=%h", timeout_o, resp_o);
    @(negedge clk_i); #1;
    chk("to_pulse_end", timeout_o, 0);
    resp_ready_i = 2'b01;
    @(negedge clk_i); resp_ready_i = '0; dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'hDEAD, 2'h0}; #1;
    chk("late_idle", busy_o, 0);
    chk("late_resp_ready", dmi_resp_ready_o, 1);
    @(negedge clk_i); dmi_resp_valid_i = 1'b0; #1;
    chk("late_discard", busy_o, 0);
    run_read(0, 32'h0000BEEF, "post_to");

    // Backpressure on both the slave request and the requester response.
    @(negedge clk_i); set_reqs(RD, RD); req_valid_i = 2'b01; dmi_req_ready_i = 1'b0; #1;
    chk("bp_accept", req_ready_o, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (k == 0) begin req_valid_i = '0; req_i = '1; end
      #1;
      chk($sformatf("bp_dv%0d", k), dmi_req_valid_o, 1);
      chk($sformatf("bp_dreq%0d", k), dmi_req_o, r0rd);
    end
    @(negedge clk_i); dmi_req_ready_i = 1'b1; #1;
    chk("bp_dreq_last", dmi_req_o, r0rd);
    @(negedge clk_i); dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'hA5A5A5A5, 2'h0}; #1;
    chk("bp_resp_ready", dmi_resp_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (k == 0) begin dmi_resp_valid_i = 1'b0; dmi_resp_i = '1; end
      #1;
      chk($sformatf("bp_rv%0d", k), resp_valid_o, 2'b01);
      chk($sformatf("bp_resp%0d", k), resp_o, {32'hA5A5A5A5, 2'h0});
    end
    @(negedge clk_i); resp_ready_i = 2'b01; #1;
    chk("bp_rv_ack", resp_valid_o, 2'b01);
    @(negedge clk_i); resp_ready_i = '0; #1;
    chk("bp_idle", busy_o, 0);
    $display("backpressure txn: resp held %h", 34'({32'hA5A5A5A5, 2'h0}));

    // Reset while waiting on the slave, with a request still pending.
    @(negedge clk_i); set_reqs(RD, RD); req_valid_i = 2'b01; dmi_req_ready_i = 1'b1; #1;
    chk("rst_accept", req_ready_o, 2'b01);
    @(negedge clk_i); #1;
    @(negedge clk_i); #1;
    chk("rst_in_wait", dmi_resp_ready_o, 1);
    chk("rst_busy", busy_o, 1);
    rst_ni = 1'b0; #1;
    check_all_zero("rst_mid");
    @(negedge clk_i); #1;
    check_all_zero("rst_hold");
    @(negedge clk_i); rst_ni = 1'b1; req_valid_i = '0; dmi_req_ready_i = 1'b0;
    run_read(0, 32'h600D0001, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
